data_mem_be: RTL and testbench

DATA_MEM_BE -- requirements
Module: data_mem_be

---
 rtl/data_mem_be_pkg.sv | 32 +++
 rtl/data_mem_be_lane.sv | 32 +++
 rtl/data_mem_be.sv | 145 ++++++++++++++
 tb/tb_data_mem_be.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_be_pkg.sv
// Shared encodings for the byte-enable data memory: funct3 codes, error codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_be_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_OOR        = 2'b10,
    ERR_ILLEGAL    = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01,
    RESP      = 2'b10
  } state_e;

  // Stores only know B/H/W; loads add the unsigned byte/half variants.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_mem_be_lane.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module mem_lane_extend
  import data_mem_be_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // Lane select followed by extension chosen by funct3
  always_comb begin
    shifted = word >> {byte_off, 3'b000};
    b       = shifted[7:0];
    h       = byte_off[1] ? word[31:16] : word[15:0];
    data    = word;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'h0, b};
      F3_HU:   data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// Single-outstanding RV32I data memory with per-byte write enables and error reporting.
// Latency: store/error response 1 cycle after acceptance, good load READ_LAT+1 cycles.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module data_mem_be
  import data_mem_be_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_e            state, state_nxt;
  logic [2:0]        cnt;
  logic [31:0]       mem  [MEM_WORDS];
  logic [31:0]       pipe [READ_LAT];
  logic [31:0]       rdata_q;
  err_e              err_q;

  logic              accept;
  logic              mis, oor, legal;
  err_e              req_err;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word, ld_data, st_data;
  logic [3:0]        be;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && (state == IDLE);
  assign idx       = req_addr[IDX_W+1:2];
  assign rd_word   = mem[idx];
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Request decode: error classification with illegal > misaligned > out-of-range
  always_comb begin
    legal = f3_legal(req_write, req_funct3);
    case (req_funct3[1:0])
      2'b01:   mis = req_addr[0];
      2'b10:   mis = (req_addr[1:0] != 2'b00);
      default: mis = 1'b0;
    endcase
    oor = (req_addr[31:2] >= 30'(MEM_WORDS));
    if (!legal)   req_err = ERR_ILLEGAL;
    else if (mis) req_err = ERR_MISALIGNED;
    else if (oor) req_err = ERR_OOR;
    else          req_err = ERR_OK;
  end

  // Store lane replication and byte enables
  always_comb begin
    st_data = req_wdata;
    be      = 4'b0000;
    case (req_funct3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        be      = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        be      = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        st_data = req_wdata;
        be      = 4'b1111;
      end
      default: begin
        st_data = req_wdata;
        be      = 4'b0000;
      end
    endcase
  end

  mem_lane_extend u_lane (
    .word     (rd_word),
    .funct3   (req_funct3),
    .byte_off (req_addr[1:0]),
    .data     (ld_data)
  );

  // Byte-enabled store commit on the acceptance edge; suppressed by reset, array itself never reset
  always_ff @(posedge clk) begin
    if (!rst && accept && req_write && (req_err == ERR_OK)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Load data captured at acceptance and shifted through a READ_LAT-deep pipe
  always_ff @(posedge clk) begin
    if (accept) pipe[0] <= ld_data;
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Next-state: stores and errors go straight to RESP, good loads wait READ_LAT cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = (req_write || (req_err != ERR_OK)) ? RESP : LOAD_WAIT;
      LOAD_WAIT: if (cnt == 3'(READ_LAT - 1)) state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register and LOAD_WAIT cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == LOAD_WAIT && state_nxt == LOAD_WAIT) ? cnt + 3'd1 : 3'd0;
    end
  end

  // Response registers, loaded on entry to RESP and held while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= ERR_OK;
    end else if (accept && (req_write || (req_err != ERR_OK))) begin
      rdata_q <= 32'h0;
      err_q   <= req_err;
    end else if (state == LOAD_WAIT && state_nxt == RESP) begin
      rdata_q <= pipe[READ_LAT-1];
      err_q   <= ERR_OK;
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Randomized plus directed check of data_mem_be against a byte-array reference model.
// Latency: checks 1-cycle store/error and READ_LAT+1 load responses.
// Backpressure: exercises RESP stalls and ignored requests outside IDLE.
module tb_data_mem_be;
  import data_mem_be_pkg::*;

  localparam int MW = 64;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mdl [MW*4];

  data_mem_be #(.MEM_WORDS(MW), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte array, errors by priority, extension by arithmetic
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic [1:0] er, output int lat);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    if (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) er = 2'd3;
    else if ((a & 32'(size - 1)) != 0)                er = 2'd1;
    else if ((a >> 2) >= MW)                          er = 2'd2;
    else                                              er = 2'd0;
    rd  = 32'h0;
    lat = 1;
    if (er == 2'd0) begin
      if (w) begin
        for (int i = 0; i < size; i++) mdl[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mdl[a + i]) << (8 * i));
        if (f3 == F3_B) v = {{24{v[7]}}, v[7:0]};
        if (f3 == F3_H) v = {{16{v[15]}}, v[15:0]};
        rd  = v;
        lat = RL + 1;
      end
    end
  endtask

  // One full transaction; junk requests are driven while busy and must be ignored
  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    logic [31:0] erd;
    logic [1:0]  eer;
    int elat, lat;
    model(w, f3, a, wd, erd, eer, elat);
    @(negedge clk);
    check({tag, ":ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_W; req_addr = $urandom_range(0, MW*4-1) & ~32'h3;
    req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    check({tag, ":lat"},   32'(lat), 32'(elat));
    check({tag, ":rdata"}, rsp_rdata, erd);
    check({tag, ":err"},   {30'h0, rsp_err}, {30'h0, eer});
    @(negedge clk);
    check({tag, ":done"},  {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] hold_rd;
    logic [1:0]  hold_er;
    logic [31:0] a;
    logic [2:0]  f3;
    logic        w;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err",   {30'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < MW; i++) txn(1'b1, F3_W, 32'(i * 4), $urandom, "fill");

    txn(1'b1, F3_W,  32'h10, 32'hDEADBEEF, "sw10");
    txn(1'b0, F3_W,  32'h10, 32'h0, "lw10");
    txn(1'b1, F3_B,  32'h13, 32'h00000080, "sb13");
    txn(1'b0, F3_B,  32'h13, 32'h0, "lb13");
    txn(1'b0, F3_BU, 32'h13, 32'h0, "lbu13");
    txn(1'b0, F3_W,  32'h10, 32'h0, "lw10b");
    txn(1'b0, F3_W,  32'h12, 32'h0, "lw12_mis");
    txn(1'b1, F3_H,  32'h11, 32'h1234, "sh11_mis");
    txn(1'b0, F3_W,  32'h10, 32'h0, "lw10c");
    txn(1'b0, F3_W,  32'(MW * 4), 32'h0, "lw_oor");
    txn(1'b0, 3'b011, 32'h10, 32'h0, "ld_ill");
    txn(1'b1, 3'b100, 32'h11, 32'h0, "st_ill_prio");
    txn(1'b1, F3_H,  32'h16, 32'hABCD8765, "sh16");
    txn(1'b0, F3_H,  32'h16, 32'h0, "lh16");
    txn(1'b0, F3_HU, 32'h16, 32'h0, "lhu16");

    // Stall in RESP: outputs stable, req_ready low, stray store ignored
    model(1'b0, F3_W, 32'h10, 32'h0, hold_rd, hold_er, a);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 30 && rsp_valid !== 1'b1; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'h0, rsp_valid}, 32'h1);
      check("stall_rdata", rsp_rdata, hold_rd);
      check("stall_err",   {30'h0, rsp_err}, {30'h0, hold_er});
      check("stall_ready", {31'h0, req_ready}, 32'h0);
      req_valid = (k == 2); req_write = 1'b1; req_funct3 = F3_W;
      req_addr = 32'h30; req_wdata = 32'h55AA55AA;
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {31'h0, rsp_valid}, 32'h0);
    txn(1'b0, F3_W, 32'h30, 32'h0, "lw30_after_stray");

    // Reset during LOAD_WAIT drops the load
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rlw_ready", {31'h0, req_ready}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      check("rlw_novalid", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
    end

    // Reset while waiting in RESP clears response outputs
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h12; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rresp_err_pre", {30'h0, rsp_err}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    check("rresp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rresp_err",   {30'h0, rsp_err}, 32'h0);

    // Store presented on a reset edge must not commit
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_st_novalid", {31'h0, rsp_valid}, 32'h0);
    txn(1'b0, F3_W, 32'h20, 32'h0, "lw20_after_rst_st");

    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'(MW * 4) + $urandom_range(0, 15);
      else                           a = $urandom_range(0, MW*4-1);
      txn(w, f3, a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
